// File: rtl/toy_cpu_core.sv
// toy_cpu_core: single-cycle 8-bit accumulator-style toy CPU.
//
// Ports:
//   clk      - system clock, all state commits on the rising edge
//   reset    - asynchronous active-high reset (pc=32, registers and flags cleared)
//   switches - 16-bit external data for CPW (code write) and IN (data input)
//   pc       - current program counter
//   halted   - high while the fetched instruction is HALT
//
// Build option: TOY_CPU_SWITCH_IO_EN enables the IN and CPW opcodes. When it
// is undefined, both opcodes behave as NOP and switches is ignored.
//
// Instruction word: op=[15:12] rd=[11:10] rs=[9:8] imm=[7:0].
// Neither memory is cleared by reset.

module code_memory (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [5:0]  waddr,
    input  logic [15:0] wdata,
    input  logic [5:0]  raddr,
    output logic [15:0] rdata
);
    logic [15:0] memory_array [0:63];

    always_ff @(posedge clk) begin
        if (we && !reset) memory_array[waddr] <= wdata;
    end

    assign rdata = memory_array[raddr];
endmodule

module data_memory (
    input  logic       clk,
    input  logic       reset,
    input  logic       we,
    input  logic [3:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata
);
    logic [7:0] memory_array [0:15];

    always_ff @(posedge clk) begin
        if (we && !reset) memory_array[addr] <= wdata;
    end

    assign rdata = memory_array[addr];
endmodule

module toy_cpu_core (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] switches,
    output logic [5:0]  pc,
    output logic        halted
);
    logic [5:0]  pc_q, pc_d;
    logic [7:0]  regs_q [0:3];
    logic [7:0]  regs_d [0:3];
    logic        n_q, z_q, c_q, v_q;
    logic        n_d, z_d, c_d, v_d;

    logic [15:0] instr;
    logic [3:0]  op;
    logic [1:0]  rd, rs;
    logic [7:0]  imm;
    logic [7:0]  rd_val, rs_val;
    logic [7:0]  alu_b, alu_res;
    logic [1:0]  alu_sel;
    logic [8:0]  sum9, diff9;
    logic        alu_c, alu_v;
    logic [5:0]  branch_target;
    logic        cond_true;
    logic [3:0]  dmem_addr;
    logic [7:0]  dmem_rdata, dmem_wdata;
    logic        dmem_we, cmem_we;

`ifdef TOY_CPU_SWITCH_IO_EN
`else
    logic unused_switches;
    assign unused_switches = ^switches;
`endif

    code_memory code_memory (
        .clk   (clk),
        .reset (reset),
        .we    (cmem_we),
        .waddr (imm[5:0]),
        .wdata (switches),
        .raddr (pc_q),
        .rdata (instr)
    );

    data_memory data_memory (
        .clk   (clk),
        .reset (reset),
        .we    (dmem_we),
        .addr  (dmem_addr),
        .wdata (dmem_wdata),
        .rdata (dmem_rdata)
    );

    assign op  = instr[15:12];
    assign rd  = instr[11:10];
    assign rs  = instr[9:8];
    assign imm = instr[7:0];

    assign rd_val = regs_q[rd];
    assign rs_val = regs_q[rs];

    // Only the low nibble of R[rs]+imm matters, so the address wraps mod 16.
    assign dmem_addr = rs_val[3:0] + imm[3:0];

    // Adding imm[5:0] in 6 bits equals adding the sign-extended imm mod 64.
    assign branch_target = pc_q + imm[5:0];

    always_comb begin
        alu_b   = (op == 4'h5 || op == 4'h6) ? imm : rs_val;
        alu_sel = 2'b00;
        case (op)
            4'h2, 4'h6, 4'hD: alu_sel = 2'b01;
            4'h3:             alu_sel = 2'b10;
            4'h4:             alu_sel = 2'b11;
            default:          alu_sel = 2'b00;
        endcase

        sum9  = {1'b0, rd_val} + {1'b0, alu_b};
        diff9 = {1'b0, rd_val} - {1'b0, alu_b};
        alu_res = sum9[7:0];
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (alu_sel)
            2'b00: begin
                alu_res = sum9[7:0];
                alu_c   = sum9[8];
                alu_v   = (rd_val[7] == alu_b[7]) && (alu_res[7] != rd_val[7]);
            end
            2'b01: begin
                // Carry means "no borrow", i.e. A >= B unsigned.
                alu_res = diff9[7:0];
                alu_c   = ~diff9[8];
                alu_v   = (rd_val[7] != alu_b[7]) && (alu_res[7] != rd_val[7]);
            end
            2'b10:   alu_res = rd_val & alu_b;
            default: alu_res = rd_val ^ alu_b;
        endcase
    end

    always_comb begin
        cond_true = 1'b0;
        case (instr[10:8])
            3'd0:    cond_true = z_q;
            3'd1:    cond_true = !z_q;
            3'd2:    cond_true = c_q;
            3'd3:    cond_true = !c_q;
            3'd4:    cond_true = n_q;
            3'd5:    cond_true = !n_q;
            3'd6:    cond_true = v_q;
            default: cond_true = !v_q;
        endcase
        // Conditions 8-15 are never taken.
        if (instr[11]) cond_true = 1'b0;
    end

    always_comb begin
        pc_d       = pc_q + 6'd1;
        regs_d     = regs_q;
        n_d        = n_q;
        z_d        = z_q;
        c_d        = c_q;
        v_d        = v_q;
        dmem_we    = 1'b0;
        dmem_wdata = rd_val;
        cmem_we    = 1'b0;
        case (op)
            4'h0: pc_d = pc_q;
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hD: begin
                if (op != 4'hD) regs_d[rd] = alu_res;
                n_d = alu_res[7];
                z_d = (alu_res == 8'h00);
                c_d = alu_c;
                v_d = alu_v;
            end
            4'h8: regs_d[rd] = imm;
            4'h9: regs_d[rd] = dmem_rdata;
            4'hA: begin
`ifdef TOY_CPU_SWITCH_IO_EN
                dmem_we    = 1'b1;
                dmem_wdata = switches[7:0];
`else
                // IN acts as NOP in this build.
`endif
            end
            4'hB: dmem_we = 1'b1;
            4'hC: begin
`ifdef TOY_CPU_SWITCH_IO_EN
                cmem_we = 1'b1;
`else
                // CPW acts as NOP in this build.
`endif
            end
            4'hE: pc_d = branch_target;
            4'hF: if (cond_true) pc_d = branch_target;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q   <= 6'd32;
            regs_q <= '{default: 8'h00};
            n_q    <= 1'b0;
            z_q    <= 1'b0;
            c_q    <= 1'b0;
            v_q    <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            regs_q <= regs_d;
            n_q    <= n_d;
            z_q    <= z_d;
            c_q    <= c_d;
            v_q    <= v_d;
        end
    end

    assign pc     = pc_q;
    assign halted = (op == 4'h0);
endmodule

// File: tb/tb_toy_cpu_core.sv
module tb_toy_cpu_core;
    logic        clk;
    logic        reset;
    logic [15:0] switches;
    logic [5:0]  pc;
    logic        halted;

    toy_cpu_core dut (
        .clk      (clk),
        .reset    (reset),
        .switches (switches),
        .pc       (pc),
        .halted   (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind: 0 check register idx, 1 check DMEM[idx], 2 pc/flags only
    typedef struct {
        logic [15:0] instr;
        logic [1:0]  kind;
        logic [3:0]  idx;
        logic [7:0]  val;
        logic [3:0]  flags;   // {N,Z,C,V}
        logic [5:0]  pc_next;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_mems();
        for (int i = 0; i < 64; i++) dut.code_memory.memory_array[i] = 16'h0000;
        for (int i = 0; i < 16; i++) dut.data_memory.memory_array[i] = 8'h00;
    endtask

    task automatic begin_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    task automatic end_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [3:0] flags_now();
        return {dut.n_q, dut.z_q, dut.c_q, dut.v_q};
    endfunction

    initial begin
        vec_t v;
        logic [5:0] wpc;

        reset    = 1'b0;
        switches = 16'h0000;

        vecs.push_back('{16'h8005, 2'd0, 4'd0, 8'h05, 4'b0000, 6'd33}); // LDI R0,5
        vecs.push_back('{16'h8403, 2'd0, 4'd1, 8'h03, 4'b0000, 6'd34}); // LDI R1,3
        vecs.push_back('{16'h2100, 2'd0, 4'd0, 8'h02, 4'b0010, 6'd35}); // SUB R0,R1
        vecs.push_back('{16'h8800, 2'd0, 4'd2, 8'h00, 4'b0010, 6'd36}); // LDI R2,0
        vecs.push_back('{16'hB204, 2'd1, 4'd4, 8'h02, 4'b0010, 6'd37}); // ST R0,[R2+4]
        vecs.push_back('{16'h8C7F, 2'd0, 4'd3, 8'h7F, 4'b0010, 6'd38}); // LDI R3,7F
        vecs.push_back('{16'h5C01, 2'd0, 4'd3, 8'h80, 4'b1001, 6'd39}); // ADDI R3,1
        vecs.push_back('{16'h8CFF, 2'd0, 4'd3, 8'hFF, 4'b1001, 6'd40}); // LDI R3,FF
        vecs.push_back('{16'h5C01, 2'd0, 4'd3, 8'h00, 4'b0110, 6'd41}); // ADDI R3,1
        vecs.push_back('{16'h3D00, 2'd0, 4'd3, 8'h00, 4'b0100, 6'd42}); // AND R3,R1
        vecs.push_back('{16'h9604, 2'd0, 4'd1, 8'h02, 4'b0100, 6'd43}); // LD R1,[R2+4]
        vecs.push_back('{16'h4400, 2'd0, 4'd1, 8'h00, 4'b0100, 6'd44}); // XOR R1,R0
        vecs.push_back('{16'hD100, 2'd0, 4'd0, 8'h02, 4'b0010, 6'd45}); // CMP R0,R1
        vecs.push_back('{16'hF003, 2'd2, 4'd0, 8'h00, 4'b0010, 6'd46}); // BZ +3 (not taken)
        vecs.push_back('{16'hF102, 2'd2, 4'd0, 8'h00, 4'b0010, 6'd48}); // BNZ +2 (taken)
        vecs.push_back('{16'h6003, 2'd0, 4'd0, 8'hFF, 4'b1000, 6'd49}); // SUBI R0,3
        vecs.push_back('{16'hE00A, 2'd2, 4'd0, 8'h00, 4'b1000, 6'd59}); // JMP +10
        vecs.push_back('{16'hF905, 2'd2, 4'd0, 8'h00, 4'b1000, 6'd60}); // cond 9: never
        vecs.push_back('{16'hF405, 2'd2, 4'd0, 8'h00, 4'b1000, 6'd1});  // BN +5 wraps to 1
        vecs.push_back('{16'h8890, 2'd0, 4'd2, 8'h90, 4'b1000, 6'd2});  // LDI R2,90
        vecs.push_back('{16'h1A00, 2'd0, 4'd2, 8'h20, 4'b0011, 6'd3});  // ADD R2,R2
        vecs.push_back('{16'h7000, 2'd2, 4'd0, 8'h00, 4'b0011, 6'd4});  // NOP
        vecs.push_back('{16'h0000, 2'd2, 4'd0, 8'h00, 4'b0011, 6'd4});  // HALT
        vecs.push_back('{16'h0000, 2'd2, 4'd0, 8'h00, 4'b0011, 6'd4});  // HALT holds

        // Reset with zeroed code memory.
        begin_reset();
        clear_mems();
        #1;
        check("rst_pc_during", {26'd0, pc}, 32'd32);
        end_reset();
        check("rst_pc", {26'd0, pc}, 32'd32);
        check("rst_halted", {31'd0, halted}, 32'd1);
        for (int i = 0; i < 4; i++) check("rst_reg", {24'd0, dut.regs_q[i]}, 32'd0);
        check("rst_flags", {28'd0, flags_now()}, 32'd0);
        cycles(10);
        check("rst_pc_hold", {26'd0, pc}, 32'd32);
        check("rst_halted_hold", {31'd0, halted}, 32'd1);

        // Table-driven program: place each instruction where the expected pc chain lands.
        begin_reset();
        clear_mems();
        wpc = 6'd32;
        foreach (vecs[i]) begin
            dut.code_memory.memory_array[wpc] = vecs[i].instr;
            wpc = vecs[i].pc_next;
        end
        end_reset();
        foreach (vecs[i]) begin
            exp_q.push_back(vecs[i]);
            check("vec_halted", {31'd0, halted}, {31'd0, (vecs[i].instr[15:12] == 4'h0)});
            @(posedge clk);
            @(negedge clk);
            if (exp_q.size() == 0) begin
                check("vec_queue_empty", 32'd1, 32'd0);
            end else begin
                v = exp_q.pop_front();
                check("vec_pc", {26'd0, pc}, {26'd0, v.pc_next});
                check("vec_flags", {28'd0, flags_now()}, {28'd0, v.flags});
                if (v.kind == 2'd0)
                    check("vec_reg", {24'd0, dut.regs_q[v.idx[1:0]]}, {24'd0, v.val});
                else if (v.kind == 2'd1)
                    check("vec_dmem", {24'd0, dut.data_memory.memory_array[v.idx]}, {24'd0, v.val});
            end
        end

        // CMP equal then BZ +3 at pc 40.
        begin_reset();
        clear_mems();
        dut.code_memory.memory_array[32] = 16'hE007;
        dut.code_memory.memory_array[39] = 16'hD000;
        dut.code_memory.memory_array[40] = 16'hF003;
        end_reset();
        cycles(3);
        check("bz_taken_pc", {26'd0, pc}, 32'd43);

        // Same point with BNZ: not taken.
        begin_reset();
        dut.code_memory.memory_array[40] = 16'hF103;
        end_reset();
        cycles(3);
        check("bnz_not_taken_pc", {26'd0, pc}, 32'd41);

        // JMP -2 at pc 33.
        begin_reset();
        clear_mems();
        dut.code_memory.memory_array[32] = 16'h7000;
        dut.code_memory.memory_array[33] = 16'hE0FE;
        end_reset();
        cycles(2);
        check("jmp_back_pc", {26'd0, pc}, 32'd31);

        // Reset asserted mid-program aborts the instruction in flight.
        begin_reset();
        clear_mems();
        dut.code_memory.memory_array[32] = 16'h8005;
        dut.code_memory.memory_array[33] = 16'h8405;
        end_reset();
        cycles(1);
        reset = 1'b1;
        #1;
        check("async_rst_pc", {26'd0, pc}, 32'd32);
        check("async_rst_r0", {24'd0, dut.regs_q[0]}, 32'd0);
        cycles(1);
        check("async_rst_r1", {24'd0, dut.regs_q[1]}, 32'd0);
        reset = 1'b0;

        // Switch I/O: CPW imm=45, IN [R0+2], HALT.
        begin_reset();
        clear_mems();
        dut.code_memory.memory_array[32] = 16'hC02D;
        dut.code_memory.memory_array[33] = 16'hA002;
        dut.data_memory.memory_array[2]  = 8'h55;
        switches = 16'h1234;
        end_reset();
        cycles(1);
        check("sw_pc1", {26'd0, pc}, 32'd33);
        cycles(1);
        check("sw_pc2", {26'd0, pc}, 32'd34);
        check("sw_halted", {31'd0, halted}, 32'd1);
`ifdef TOY_CPU_SWITCH_IO_EN
        check("sw_cpw", {16'd0, dut.code_memory.memory_array[45]}, 32'h1234);
        check("sw_in", {24'd0, dut.data_memory.memory_array[2]}, 32'h34);
`else
        check("sw_cpw_off", {16'd0, dut.code_memory.memory_array[45]}, 32'h0000);
        check("sw_in_off", {24'd0, dut.data_memory.memory_array[2]}, 32'h55);
`endif
        switches = 16'h0000;

        // Bubble-style sort of DMEM[0..7]; restarts the scan after every swap.
        begin_reset();
        clear_mems();
        dut.code_memory.memory_array[32] = 16'h8000; // LDI R0,0
        dut.code_memory.memory_array[33] = 16'h9400; // LD R1,[R0+0]
        dut.code_memory.memory_array[34] = 16'h9801; // LD R2,[R0+1]
        dut.code_memory.memory_array[35] = 16'hD900; // CMP R2,R1
        dut.code_memory.memory_array[36] = 16'hF204; // BC +4 (in order)
        dut.code_memory.memory_array[37] = 16'hB800; // ST R2,[R0+0]
        dut.code_memory.memory_array[38] = 16'hB401; // ST R1,[R0+1]
        dut.code_memory.memory_array[39] = 16'hE0F9; // JMP -7 (restart)
        dut.code_memory.memory_array[40] = 16'h5001; // ADDI R0,1
        dut.code_memory.memory_array[41] = 16'h8C07; // LDI R3,7
        dut.code_memory.memory_array[42] = 16'hD300; // CMP R0,R3
        dut.code_memory.memory_array[43] = 16'hF1F6; // BNZ -10
        dut.code_memory.memory_array[44] = 16'h0000; // HALT
        begin
            logic [7:0] init_d [0:8];
            init_d = '{8'd7, 8'd3, 8'd2, 8'd1, 8'd6, 8'd4, 8'd5, 8'd8, 8'd7};
            for (int i = 0; i < 9; i++) dut.data_memory.memory_array[i] = init_d[i];
        end
        end_reset();
        cycles(20000);
        for (int i = 0; i < 8; i++)
            check("sort_dmem", {24'd0, dut.data_memory.memory_array[i]}, i + 1);
        check("sort_dmem8", {24'd0, dut.data_memory.memory_array[8]}, 32'd7);
        check("sort_halted", {31'd0, halted}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
